load_store_unit: RTL

- Initiator side of the data-memory interface in the multicycle MIPS datapath.
- Accepts one load/store request at a time from the CPU control (byte address, size, signedness) and drives the word-only data memory through MemRead/MemWrite, address, write data and combinational read data.
- Provides lb/lbu/lh/lhu/lw extraction with sign/zero extension.
- Provides sb/sh via read-modify-write, because the memory has no byte enables.
- Flags misaligned accesses without touching memory.

---
 rtl/load_store_unit_if.sv | 39 +++
 rtl/load_store_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Request/response channel between CPU control and the load/store unit,
// bundled with the word-only data-memory port that the unit drives.
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    // CPU request / response
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  misaligned;

    // Data memory (word addressed, combinational read)
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_write;
    logic                  mem_read;
    logic [DATA_WIDTH-1:0] mem_q;

    // Environment side: CPU control plus the memory array
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_q,
        input  req_ready, resp_valid, resp_rdata, misaligned,
        input  mem_addr, mem_wdata, mem_write, mem_read
    );

    // Load/store unit side
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_q,
        output req_ready, resp_valid, resp_rdata, misaligned,
        output mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte/half/word loads with
// sign/zero extension, sub-word stores by read-modify-write (memory has no
// byte enables), misaligned requests rejected without a memory access.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        STORE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t                state_r;
    logic [1:0]            size_r;
    logic                  unsigned_r;
    logic [1:0]            lane_r;
    logic [DATA_WIDTH-1:0] wdata_r;

    logic                  req_ready_r;
    logic                  resp_valid_r;
    logic [DATA_WIDTH-1:0] resp_rdata_r;
    logic                  misaligned_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r;
    logic                  mem_write_r;
    logic                  mem_read_r;

    logic                  misaligned_s;
    logic [ADDR_WIDTH-1:0] word_addr_s;
    logic                  unused_addr_bits_s;

    // Little-endian lane extraction with sign or zero extension.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic zext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = zext ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = zext ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed byte or half of the old word with new store data.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] r;
        r = old;
        case (size)
            2'b00: begin
                case (lane)
                    2'b00:   r[7:0]   = wd[7:0];
                    2'b01:   r[15:8]  = wd[7:0];
                    2'b10:   r[23:16] = wd[7:0];
                    2'b11:   r[31:24] = wd[7:0];
                    default: r = old;
                endcase
            end
            2'b01: begin
                if (lane[1]) begin
                    r[31:16] = wd[15:0];
                end else begin
                    r[15:0] = wd[15:0];
                end
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    assign word_addr_s        = bus.req_addr[ADDR_WIDTH+1:2];
    // Address bits above the memory size wrap and are intentionally dropped.
    assign unused_addr_bits_s = ^bus.req_addr[31:ADDR_WIDTH+2];

    // Alignment check of the incoming request against its access size.
    always_comb begin
        misaligned_s = 1'b0;
        case (bus.req_size)
            2'b00:   misaligned_s = 1'b0;
            2'b01:   misaligned_s = bus.req_addr[0];
            default: misaligned_s = (bus.req_addr[1:0] != 2'b00);
        endcase
    end

    // Request sequencer: state, request latches and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            size_r       <= 2'b00;
            unsigned_r   <= 1'b0;
            lane_r       <= 2'b00;
            wdata_r      <= '0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= '0;
            misaligned_r <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            mem_write_r  <= 1'b0;
            mem_read_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        size_r      <= bus.req_size;
                        unsigned_r  <= bus.req_unsigned;
                        lane_r      <= bus.req_addr[1:0];
                        wdata_r     <= bus.req_wdata;
                        req_ready_r <= 1'b0;
                        if (misaligned_s) begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            misaligned_r <= 1'b1;
                            resp_rdata_r <= '0;
                        end else if (!bus.req_write) begin
                            state_r    <= LOAD;
                            mem_read_r <= 1'b1;
                            mem_addr_r <= word_addr_s;
                        end else if (bus.req_size[1]) begin
                            state_r     <= STORE;
                            mem_write_r <= 1'b1;
                            mem_addr_r  <= word_addr_s;
                            mem_wdata_r <= bus.req_wdata;
                        end else begin
                            state_r    <= RMW_RD;
                            mem_read_r <= 1'b1;
                            mem_addr_r <= word_addr_s;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    resp_rdata_r <= load_extract(bus.mem_q, size_r, lane_r, unsigned_r);
                    mem_read_r   <= 1'b0;
                    mem_addr_r   <= '0;
                    resp_valid_r <= 1'b1;
                    state_r      <= RESP;
                end
                RMW_RD: begin
                    // mem_addr stays put so the write hits the word just read.
                    mem_wdata_r <= store_merge(bus.mem_q, wdata_r, size_r, lane_r);
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b1;
                    state_r     <= STORE;
                end
                STORE: begin
                    mem_write_r  <= 1'b0;
                    mem_addr_r   <= '0;
                    mem_wdata_r  <= '0;
                    resp_valid_r <= 1'b1;
                    state_r      <= RESP;
                end
                RESP: begin
                    resp_valid_r <= 1'b0;
                    misaligned_r <= 1'b0;
                    req_ready_r  <= 1'b1;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    misaligned_r <= 1'b0;
                    mem_read_r   <= 1'b0;
                    mem_write_r  <= 1'b0;
                    mem_addr_r   <= '0;
                    mem_wdata_r  <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.misaligned = misaligned_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.mem_write  = mem_write_r;
    assign bus.mem_read   = mem_read_r;
endmodule
